// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// State encoding and the index-width helper used by the top and the picker.
package rr_arb_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    S_IDLE   = ST_IDLE,
    S_LOCKED = ST_LOCKED
  } arb_state_e;

  // Index width that never collapses to zero bits, so N_REQ=1 still has a port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Rotates the request vector down by ptr, isolates the lowest set bit, rotates back.
module rr_priority_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] rot_dbl;
  logic [N_REQ-1:0]   rot_req;
  logic [N_REQ-1:0]   rot_oh;
  logic [2*N_REQ-1:0] back_dbl;
  logic               found;

  always_comb begin
    req_dbl  = {req, req};
    rot_dbl  = req_dbl >> ptr;
    rot_req  = rot_dbl[N_REQ-1:0];
    rot_oh   = '0;
    found    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rot_req[k] && !found) begin
        rot_oh[k] = 1'b1;
        found     = 1'b1;
      end
    end
    back_dbl = {rot_oh, rot_oh} << ptr;
    pick_oh  = back_dbl[2*N_REQ-1:N_REQ];
  end

  always_comb begin
    pick_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick_oh[j]) pick_idx = IDX_W'(j);
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter steering N_REQ producers onto one ready/valid channel.
// Optional watchdog on grant hold time is enabled by defining RR_ARB_WDOG_EN.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = clog2_min1(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant_oh,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy,
  output logic                    timeout_err
);

  if (N_REQ < 1 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_mux_arbiter: N_REQ and MAX_HOLD must both be at least 1");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             xfer_last;
  logic             wdog_fire;
  logic [IDX_W-1:0] ptr_after_grant;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // grant_oh_q is zero outside LOCKED, so the AND-OR mux idles at zero for free.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh_q[i]) out_data = out_data | req_data[i*DATA_W +: DATA_W];
    end
  end

  assign out_valid = |(req_valid & grant_oh_q);
  assign out_last  = |(req_last & grant_oh_q);
  assign req_ready = grant_oh_q & {N_REQ{out_ready}};
  assign xfer_last = |(req_valid & req_last & grant_oh_q) & out_ready;

  assign ptr_after_grant = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0
                                                              : grant_idx_q + IDX_W'(1);

`ifdef RR_ARB_WDOG_EN
  localparam int HOLD_W = clog2_min1(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  assign wdog_fire = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  // Counter sits at zero in IDLE, so each LOCKED tenure starts counting from 0.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == S_LOCKED) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    timeout_d = (state_q == S_LOCKED) && wdog_fire && !xfer_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wdog_fire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_oh_d  = pick_oh;
          grant_idx_d = pick_idx;
          state_d     = S_LOCKED;
        end
      end
      S_LOCKED: begin
        // A closing beat wins over a watchdog expiry in the same cycle.
        if (xfer_last || wdog_fire) begin
          state_d     = S_IDLE;
          rr_ptr_d    = ptr_after_grant;
          grant_oh_d  = '0;
          grant_idx_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        grant_oh_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant_oh  = grant_oh_q;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == S_LOCKED);

endmodule
